fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
- Read-domain controller of the async FIFO.
- Consumes the write-side Gray pointer after it has been synchronised into clk by the two-flop synchroniser.
- Maintains the read pointer, exports it as a registered Gray code for the write domain, and derives the empty, almost-empty and level indications.
- Drives a 1-cycle-latency synchronous-read RAM and presents data on a first-word-fall-through valid/ready output backed by a 2-entry output buffer, sustaining 1 word/cycle.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 6, RAM address width. Depth is 2^ADDR_W; pointers are ADDR_W+1 bits.
- AEMPTY_THRESH, 4, almost_empty asserts when rd_level <= this value.

Ports:
- clk  in  1  read-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wq2_gptr  in  ADDR_W+1  write Gray pointer, already synchronised into clk.
- rd_gptr  out  ADDR_W+1  registered Gray read pointer, sent to the write domain.
- mem_raddr  out  ADDR_W  RAM read address, equal to rbin[ADDR_W-1:0].
- mem_ren  out  1  RAM read enable.
- mem_rdata  in  DATA_W  RAM data, valid in the cycle after mem_ren is sampled.
- dout  out  DATA_W  head word of the output buffer.
- dout_valid  out  1  head word is valid.
- dout_ready  in  1  consumer accepts the head word.
- rd_level  out  ADDR_W+1  words in RAM not yet fetched, read-domain view.
- empty  out  1  RAM holds no unfetched word.
- almost_empty  out  1  rd_level <= AEMPTY_THRESH.

Behaviour:
- Reset (asynchronous): rbin=0, rd_gptr=0, empty=1, almost_empty=1, rd_level=0, inflight=0, output buffer count=0, dout=0, dout_valid=0. mem_ren=0 because empty=1.
- Definitions:
  - pop = dout_valid & dout_ready.
  - credit = 2 - ob_cnt - inflight + pop, evaluated combinationally.
  - mem_ren = !empty & (credit > 0).
- Pointer update:
  - rbin_next = rbin + mem_ren, modulo 2^(ADDR_W+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - Both rbin and rd_gptr are registered.
- Empty flag:
  - empty <= (rgray_next == wq2_gptr), registered.
  - Look-ahead compare, so no extra RAM read is ever issued past the write pointer.
- Level:
  - wbin = gray-to-binary(wq2_gptr).
  - rd_level <= (wbin - rbin_next) modulo 2^(ADDR_W+1), registered.
  - Range is 0..2^ADDR_W; 64 means the RAM is full.
  - almost_empty <= (that same value <= AEMPTY_THRESH), registered.
- Inflight flag:
  - inflight <= mem_ren.
  - When inflight=1, mem_rdata is written into the output buffer tail on that edge.
- Output buffer:
  - 2-entry FIFO; dout is always the head register.
  - Push (inflight) and pop on the same edge are allowed.
  - The credit rule guarantees a push never finds the buffer full; overflow is impossible by construction.
- Latency: wq2_gptr changes after edge E0 → empty falls at E1 → mem_ren high in the following cycle → RAM read at E2 → dout_valid rises at E3.
- Throughput: with dout_ready held high, one word per cycle in steady state.
- Backpressure: with dout_ready low, at most 2 words are buffered and mem_ren stays 0 once ob_cnt + inflight = 2.
- Wrap-around: the MSB of the (ADDR_W+1)-bit pointer distinguishes laps. Read address 2^ADDR_W-1 is followed by address 0 with the MSB toggled.
- Simultaneous write-pointer advance and read: the compare uses rgray_next, so both take effect on the same edge.
- Gray input settling: wq2_gptr may change by at most 1 code per clk. Any larger step is a synchroniser/write-side fault and is not checked here.
- Reset mid-operation: rst_n low at any point returns all state to the reset values immediately, and buffered words are discarded. The write side must be reset together with this block.

Decomposition:
- Package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterised on width;
  - the pointer width constant PTR_W = ADDR_W+1;
  - the output buffer depth constant OB_DEPTH = 2.
- One sub-module, fifo_out_buf: the 2-entry output buffer. It has push/pop/data in/head out and ob_cnt.

Test Plan:
- Reset checks: assert rst_n low with wq2_gptr=7'h05 → rd_gptr=0, empty=1, almost_empty=1, rd_level=0, dout_valid=0, mem_ren=0.
- Single word: RAM[0]=16'hA5A5; step wq2_gptr 0→1 after E0 → empty=0 at E1; mem_ren=1 with mem_raddr=0; dout_valid=1 with dout=16'hA5A5 at E3; rd_gptr=7'h01.
- Full burst: wq2_gptr jumps through Gray codes 1..64 one per cycle (64 → 7'h60) with dout_ready=1 → rd_level peaks without exceeding 64; 64 consecutive words are delivered in address order; empty returns to 1 with rd_gptr=7'h60.
- Backpressure: 10 words available and dout_ready=0 → exactly 2 RAM reads occur, then mem_ren=0 and rd_level=8; release dout_ready → the remaining 8 words stream at 1/cycle.
- Wrap-around: preload rbin=60 and stream 8 words → mem_raddr sequence is 60,61,62,63,0,1,2,3 and rd_gptr MSB toggles.
- Mid-stream reset: pulse rst_n low while dout_valid=1 and inflight=1 → all outputs return to reset values asynchronously, with no spurious dout_valid after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and Gray-code helpers for the async FIFO
//
// Purpose : pointer/buffer sizing constants and width-agnostic Gray <-> binary
//           conversion used by both FIFO clock domains.
// Contents: FIFO_ADDR_W, PTR_W, OB_DEPTH, OB_CNT_W, CODE_W, bin2gray, gray2bin.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 6;
  localparam int PTR_W       = FIFO_ADDR_W + 1;
  localparam int OB_DEPTH    = 2;
  localparam int OB_CNT_W    = $clog2(OB_DEPTH + 1);

  // Helpers operate on a wide container. Any narrower pointer is zero-extended
  // on the way in and truncated on the way out. Zero upper bits leave the
  // conversion of the low bits unchanged, so one function serves every width.
  localparam int CODE_W = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - 2-entry first-word-fall-through output buffer
//
// Purpose : holds words returned by the RAM until the consumer takes them.
//           head_o is always the head register. Push and pop may coincide.
// Ports   : clk, rst_n (async, active-low)
//           push_i   - write data_i into the tail this edge
//           pop_i    - drop the head this edge (only asserted while valid_o)
//           data_i   - incoming word
//           head_o   - head word
//           valid_o  - head word is valid
//           cnt_o    - number of buffered words (0..OB_DEPTH)
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   head_o,
  output logic                valid_o,
  output logic [OB_CNT_W-1:0] cnt_o
);

  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   tail_q, tail_d;
  logic [OB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == '0) head_d = data_i;
        else             tail_d = data_i;
        cnt_d = cnt_q + OB_CNT_W'(1);
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - OB_CNT_W'(1);
      end
      2'b11: begin
        // Count is unchanged; the new word lands behind whatever survives.
        if (cnt_q == OB_CNT_W'(OB_DEPTH)) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (cnt_q != '0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-domain controller of the async FIFO
//
// Purpose : tracks the read pointer against the synchronised write Gray
//           pointer, issues RAM reads into a 2-entry FWFT output buffer and
//           reports empty / almost-empty / level in the read domain.
// Ports   : clk, rst_n (async, active-low)
//           wq2_gptr     - write Gray pointer, already synchronised into clk
//           rd_gptr      - registered Gray read pointer for the write domain
//           mem_raddr    - RAM read address (low bits of the binary pointer)
//           mem_ren      - RAM read enable
//           mem_rdata    - RAM data, valid the cycle after mem_ren
//           dout         - head word of the output buffer
//           dout_valid   - head word valid
//           dout_ready   - consumer accepts the head word
//           rd_level     - words in RAM not yet fetched
//           empty        - RAM holds no unfetched word
//           almost_empty - rd_level <= AEMPTY_THRESH
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 6,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wq2_gptr,
  output logic [ADDR_W:0]   rd_gptr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W:0]   rd_level,
  output logic              empty,
  output logic              almost_empty
);

  localparam int RP_W  = ADDR_W + 1;
  localparam int OCC_W = OB_CNT_W + 1;

  logic [RP_W-1:0]     rbin_q, rbin_d;
  logic [RP_W-1:0]     rgray_q, rgray_d;
  logic [RP_W-1:0]     level_q, level_d;
  logic [RP_W-1:0]     wbin;
  logic                empty_q, empty_d;
  logic                aempty_q, aempty_d;
  logic                inflight_q;
  logic [OB_CNT_W-1:0] ob_cnt;
  logic [OCC_W-1:0]    occ, occ_limit;
  logic                pop;
  logic                ren;

  assign pop = dout_valid & dout_ready;

  // credit = OB_DEPTH - ob_cnt - inflight + pop > 0, rearranged so that no
  // intermediate goes negative: the buffer slots already spoken for must be
  // fewer than the depth plus the slot freed this cycle.
  assign occ       = OCC_W'(ob_cnt) + OCC_W'(inflight_q);
  assign occ_limit = OCC_W'(OB_DEPTH) + OCC_W'(pop);
  assign ren       = !empty_q && (occ < occ_limit);

  assign rbin_d  = rbin_q + RP_W'(ren);
  assign rgray_d = RP_W'(bin2gray(CODE_W'(rbin_d)));
  assign wbin    = RP_W'(gray2bin(CODE_W'(wq2_gptr)));

  // Compare against the next read pointer so a read and a write-pointer
  // advance on the same edge are both reflected, and no read is issued past
  // the last written word.
  assign empty_d  = (rgray_d == wq2_gptr);
  assign level_d  = wbin - rbin_d;
  assign aempty_d = (level_d <= RP_W'(AEMPTY_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      aempty_q   <= aempty_d;
      inflight_q <= ren;
    end
  end

  // The word read on the previous edge arrives now; inflight marks it.
  fifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  (mem_rdata),
    .head_o  (dout),
    .valid_o (dout_valid),
    .cnt_o   (ob_cnt)
  );

  assign rd_gptr      = rgray_q;
  assign mem_raddr    = rbin_q[ADDR_W-1:0];
  assign mem_ren      = ren;
  assign rd_level     = level_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;

endmodule
